pipe_reg_elastic: RTL and testbench

Parametrised, elastic pipeline register: a configurable-width, configurable-depth chain of valid-tagged stages with ready/valid backpressure, bubble collapsing and synchronous flush. It replaces the fixed inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) of the 5-stage RISC-V core. Each boundary instantiates it with its own packed payload width, so stalls and branch flushes are handled in one place.

---
 rtl/pipe_reg_elastic_pkg.sv | 25 ++
 rtl/pipe_reg_elastic_stage.sv | 35 +++
 rtl/pipe_reg_elastic.sv | 107 ++++++++++
 tb/tb_pipe_reg_elastic.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_reg_elastic_pkg.sv
// Shared core constants for the elastic pipeline boundaries: the bubble
// instruction, payload field layout of the IF/ID bus, and a sizing helper.
package pipe_reg_elastic_pkg;

  // Canonical RISC-V NOP (addi x0, x0, 0), used as the instruction bubble.
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  localparam int XLEN = 32;

  // IF/ID payload layout: {pc_next, instr}
  localparam int IFID_INSTR_OFF = 0;
  localparam int IFID_PC_OFF    = IFID_INSTR_OFF + XLEN;
  localparam int IFID_W         = IFID_PC_OFF + XLEN;

  typedef struct packed {
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] instr;
  } ifid_t;

  // Width needed to hold an occupancy count from 0 to depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_reg_elastic_stage.sv
// One valid-tagged register stage. Flush wins over load; a loaded bubble
// clears the valid bit but keeps the previous data so the bus stays quiet.
module pipe_stage
  import pipe_reg_elastic_pkg::*;
#(
  parameter int                 DATA_W     = 32,
  parameter logic [DATA_W-1:0]  BUBBLE_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              load,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  // Stage register: reset/flush load the bubble, otherwise take upstream on load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= BUBBLE_VAL;
    end else if (flush) begin
      valid <= 1'b0;
      data  <= BUBBLE_VAL;
    end else if (load) begin
      valid <= in_valid;
      if (in_valid) begin
        data <= in_data;
      end
    end
  end

endmodule

// File: rtl/pipe_reg_elastic.sv
// Elastic pipeline register: DEPTH valid-tagged stages with a ready chain
// that collapses bubbles, a synchronous flush and an occupancy counter.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds valid/data steady until it sees ready;
// ready may depend combinationally on out_ready_i but valid never depends
// on ready, and nothing on the input side reaches out_* combinationally.
module pipe_reg_elastic
  import pipe_reg_elastic_pkg::*;
#(
  parameter int                 DATA_W     = 32,
  parameter int                 DEPTH      = 1,
  parameter logic [DATA_W-1:0]  BUBBLE_VAL = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [DATA_W-1:0]             in_data_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [DATA_W-1:0]             out_data_o,
  output logic [count_width(DEPTH)-1:0] count_o
);

  localparam int CNT_W = count_width(DEPTH);

  logic [DEPTH-1:0]  v;
  logic [DEPTH-1:0]  rdy;
  logic [DEPTH-1:0]  src_v;
  logic [DATA_W-1:0] d     [DEPTH];
  logic [DATA_W-1:0] src_d [DEPTH];

  logic              chain;
  logic              accept;
  logic              emit;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_nxt;

  // Ready chain, walked from the output side: a stage can load if it is
  // empty or anything downstream of it can move. Accumulating through a
  // single variable keeps the chain free of bit-level self-feedback.
  always_comb begin
    chain = out_ready_i;
    rdy   = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      chain  = chain | ~v[k];
      rdy[k] = chain;
    end
  end

  assign in_ready_o  = rdy[0] & ~flush_i;
  assign out_valid_o = v[DEPTH-1];
  assign out_data_o  = d[DEPTH-1];

  assign accept = in_valid_i & in_ready_o;
  assign emit   = out_valid_o & out_ready_i;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign src_v[k] = in_valid_i;
      assign src_d[k] = in_data_i;
    end else begin : g_body
      assign src_v[k] = v[k-1];
      assign src_d[k] = d[k-1];
    end

    pipe_stage #(
      .DATA_W     (DATA_W),
      .BUBBLE_VAL (BUBBLE_VAL)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush_i),
      .load     (rdy[k]),
      .in_valid (src_v[k]),
      .in_data  (src_d[k]),
      .valid    (v[k]),
      .data     (d[k])
    );
  end

  // Next occupancy: one in, one out, or both (net zero).
  always_comb begin
    count_nxt = count_q;
    if (accept && !emit) begin
      count_nxt = count_q + 1'b1;
    end else if (!accept && emit) begin
      count_nxt = count_q - 1'b1;
    end
  end

  // Occupancy register; flush empties the pipe so the count restarts at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (flush_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_nxt;
    end
  end

  assign count_o = count_q;

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Directed and random checks of pipe_reg_elastic at depths 1, 2 and 3.
module tb_pipe_reg_elastic;

  localparam int          W    = 8;
  localparam logic [W-1:0] BUB1 = 8'hB1;
  localparam logic [W-1:0] BUB2 = 8'hB2;
  localparam logic [W-1:0] BUB3 = 8'h13;

  logic clk = 1'b0;
  logic reset;

  logic         flush_1, in_valid_1, in_ready_1, out_valid_1, out_ready_1;
  logic [W-1:0] in_data_1, out_data_1;
  logic [0:0]   count_1;

  logic         flush_2, in_valid_2, in_ready_2, out_valid_2, out_ready_2;
  logic [W-1:0] in_data_2, out_data_2;
  logic [1:0]   count_2;

  logic         flush_3, in_valid_3, in_ready_3, out_valid_3, out_ready_3;
  logic [W-1:0] in_data_3, out_data_3;
  logic [1:0]   count_3;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  pipe_reg_elastic #(.DATA_W(W), .DEPTH(1), .BUBBLE_VAL(BUB1)) u_d1 (
    .clk(clk), .reset(reset), .flush_i(flush_1),
    .in_valid_i(in_valid_1), .in_ready_o(in_ready_1), .in_data_i(in_data_1),
    .out_valid_o(out_valid_1), .out_ready_i(out_ready_1), .out_data_o(out_data_1),
    .count_o(count_1)
  );

  pipe_reg_elastic #(.DATA_W(W), .DEPTH(2), .BUBBLE_VAL(BUB2)) u_d2 (
    .clk(clk), .reset(reset), .flush_i(flush_2),
    .in_valid_i(in_valid_2), .in_ready_o(in_ready_2), .in_data_i(in_data_2),
    .out_valid_o(out_valid_2), .out_ready_i(out_ready_2), .out_data_o(out_data_2),
    .count_o(count_2)
  );

  pipe_reg_elastic #(.DATA_W(W), .DEPTH(3), .BUBBLE_VAL(BUB3)) u_d3 (
    .clk(clk), .reset(reset), .flush_i(flush_3),
    .in_valid_i(in_valid_3), .in_ready_o(in_ready_3), .in_data_i(in_data_3),
    .out_valid_o(out_valid_3), .out_ready_i(out_ready_3), .out_data_o(out_data_3),
    .count_o(count_3)
  );

  // Clock
  always #5 clk = ~clk;

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_1(input logic fl, input logic v, input logic [W-1:0] d, input logic r);
    flush_1 = fl; in_valid_1 = v; in_data_1 = d; out_ready_1 = r;
  endtask

  task automatic drive_2(input logic fl, input logic v, input logic [W-1:0] d, input logic r);
    flush_2 = fl; in_valid_2 = v; in_data_2 = d; out_ready_2 = r;
  endtask

  task automatic drive_3(input logic fl, input logic v, input logic [W-1:0] d, input logic r);
    flush_3 = fl; in_valid_3 = v; in_data_3 = d; out_ready_3 = r;
  endtask

  task automatic idle_all();
    drive_1(1'b0, 1'b0, '0, 1'b0);
    drive_2(1'b0, 1'b0, '0, 1'b0);
    drive_3(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      drive_2(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      drive_3(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      step();
      checks++;
      if ({out_valid_1, out_data_1, count_1} !== {1'b0, BUB1, 1'b0}) begin
        errors++;
        $display("FAIL reset_d1 got v=%b d=%h c=%0d want v=0 d=%h c=0", out_valid_1, out_data_1, count_1, BUB1);
      end
      checks++;
      if ({out_valid_2, out_data_2, count_2} !== {1'b0, BUB2, 2'd0}) begin
        errors++;
        $display("FAIL reset_d2 got v=%b d=%h c=%0d want v=0 d=%h c=0", out_valid_2, out_data_2, count_2, BUB2);
      end
      checks++;
      if ({out_valid_3, out_data_3, count_3} !== {1'b0, BUB3, 2'd0}) begin
        errors++;
        $display("FAIL reset_d3 got v=%b d=%h c=%0d want v=0 d=%h c=0", out_valid_3, out_data_3, count_3, BUB3);
      end
    end
    idle_all();
    reset = 1'b0;
    settle();
    checks++;
    if ({in_ready_1, in_ready_2, in_ready_3} !== 3'b111) begin
      errors++;
      $display("FAIL reset_release_ready got %b want 111", {in_ready_1, in_ready_2, in_ready_3});
    end
  endtask

  task automatic test_stream();
    logic [W-1:0] din [6] = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00};
    logic         ev  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [W-1:0] ed  [6] = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
    logic [1:0]   ec  [6] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0};
    for (int i = 0; i < 6; i++) begin
      drive_3(1'b0, i < 3, din[i], 1'b1);
      settle();
      checks++;
      if (in_ready_3 !== 1'b1) begin
        errors++;
        $display("FAIL stream_ready[%0d] got %b want 1", i, in_ready_3);
      end
      step();
      checks++;
      if (out_valid_3 !== ev[i] || (ev[i] && out_data_3 !== ed[i]) || count_3 !== ec[i]) begin
        errors++;
        $display("FAIL stream_out[%0d] got v=%b d=%h c=%0d want v=%b d=%h c=%0d",
                 i, out_valid_3, out_data_3, count_3, ev[i], ed[i], ec[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    drive_2(1'b0, 1'b1, 8'h0A, 1'b0);
    step();
    drive_2(1'b0, 1'b0, 8'h00, 1'b0);
    step();
    checks++;
    if ({out_valid_2, out_data_2, count_2} !== {1'b1, 8'h0A, 2'd1}) begin
      errors++;
      $display("FAIL bp_gap got v=%b d=%h c=%0d want v=1 d=0a c=1", out_valid_2, out_data_2, count_2);
    end
    drive_2(1'b0, 1'b1, 8'h0B, 1'b0);
    settle();
    checks++;
    if (in_ready_2 !== 1'b1) begin
      errors++;
      $display("FAIL bp_collapse_ready got %b want 1", in_ready_2);
    end
    step();
    drive_2(1'b0, 1'b1, 8'hCC, 1'b0);
    settle();
    checks++;
    if ({in_ready_2, count_2, out_data_2} !== {1'b0, 2'd2, 8'h0A}) begin
      errors++;
      $display("FAIL bp_full got rdy=%b c=%0d d=%h want rdy=0 c=2 d=0a", in_ready_2, count_2, out_data_2);
    end
    step();
    checks++;
    if ({count_2, out_data_2} !== {2'd2, 8'h0A}) begin
      errors++;
      $display("FAIL bp_hold got c=%0d d=%h want c=2 d=0a", count_2, out_data_2);
    end
    drive_2(1'b0, 1'b0, 8'h00, 1'b1);
    settle();
    checks++;
    if (in_ready_2 !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_ready got %b want 1", in_ready_2);
    end
    step();
    checks++;
    if ({out_valid_2, out_data_2, count_2} !== {1'b1, 8'h0B, 2'd1}) begin
      errors++;
      $display("FAIL bp_emit_b got v=%b d=%h c=%0d want v=1 d=0b c=1", out_valid_2, out_data_2, count_2);
    end
    step();
    checks++;
    if ({out_valid_2, count_2} !== {1'b0, 2'd0}) begin
      errors++;
      $display("FAIL bp_drained got v=%b c=%0d want v=0 c=0", out_valid_2, count_2);
    end
    drive_2(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive_3(1'b0, 1'b1, 8'(8'h41 + i), 1'b0);
      step();
    end
    checks++;
    if ({out_valid_3, out_data_3, count_3} !== {1'b1, 8'h41, 2'd3}) begin
      errors++;
      $display("FAIL flush_fill got v=%b d=%h c=%0d want v=1 d=41 c=3", out_valid_3, out_data_3, count_3);
    end
    drive_3(1'b1, 1'b1, 8'h99, 1'b1);
    settle();
    checks++;
    if (in_ready_3 !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready got %b want 0", in_ready_3);
    end
    step();
    checks++;
    if ({out_valid_3, out_data_3, count_3} !== {1'b0, BUB3, 2'd0}) begin
      errors++;
      $display("FAIL flush_clear got v=%b d=%h c=%0d want v=0 d=%h c=0", out_valid_3, out_data_3, count_3, BUB3);
    end
    drive_3(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({out_valid_3, out_data_3, count_3} !== {1'b0, BUB3, 2'd0}) begin
        errors++;
        $display("FAIL flush_after[%0d] got v=%b d=%h c=%0d want v=0 d=%h c=0", i, out_valid_3, out_data_3, count_3, BUB3);
      end
    end
  endtask

  task automatic test_full_simultaneous();
    drive_1(1'b0, 1'b1, 8'h5A, 1'b0);
    step();
    checks++;
    if ({out_valid_1, out_data_1, count_1} !== {1'b1, 8'h5A, 1'b1}) begin
      errors++;
      $display("FAIL d1_latency got v=%b d=%h c=%0d want v=1 d=5a c=1", out_valid_1, out_data_1, count_1);
    end
    drive_1(1'b0, 1'b1, 8'h77, 1'b0);
    settle();
    checks++;
    if (in_ready_1 !== 1'b0) begin
      errors++;
      $display("FAIL d1_full_ready got %b want 0", in_ready_1);
    end
    step();
    checks++;
    if ({out_data_1, count_1} !== {8'h5A, 1'b1}) begin
      errors++;
      $display("FAIL d1_full_hold got d=%h c=%0d want d=5a c=1", out_data_1, count_1);
    end
    drive_1(1'b0, 1'b1, 8'h5B, 1'b1);
    settle();
    checks++;
    if (in_ready_1 !== 1'b1) begin
      errors++;
      $display("FAIL d1_simul_ready got %b want 1", in_ready_1);
    end
    step();
    checks++;
    if ({out_valid_1, out_data_1, count_1} !== {1'b1, 8'h5B, 1'b1}) begin
      errors++;
      $display("FAIL d1_simul got v=%b d=%h c=%0d want v=1 d=5b c=1", out_valid_1, out_data_1, count_1);
    end
    drive_1(1'b0, 1'b0, 8'h00, 1'b1);
    step();
    checks++;
    if ({out_valid_1, out_data_1, count_1} !== {1'b0, 8'h5B, 1'b0}) begin
      errors++;
      $display("FAIL d1_empty got v=%b d=%h c=%0d want v=0 d=5b c=0", out_valid_1, out_data_1, count_1);
    end
    drive_1(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  // Scoreboard: exp_q holds accepted entries in order; emitted data must
  // match the head, and the DUT count must equal the queue depth.
  task automatic test_random();
    logic         fl, v, r, exp_rdy;
    logic [W-1:0] d;
    exp_q.delete();
    for (int i = 0; i < 508; i++) begin
      if (i < 500) begin
        fl = ($urandom_range(0, 31) == 0);
        v  = ($urandom_range(0, 3) != 0);
        r  = ($urandom_range(0, 2) != 0);
        d  = 8'($urandom_range(0, 255));
      end else begin
        fl = 1'b0; v = 1'b0; r = 1'b1; d = 8'h00;
      end
      drive_3(fl, v, d, r);
      settle();
      exp_rdy = !fl && (exp_q.size() < 3 || r);
      checks++;
      if (in_ready_3 !== exp_rdy) begin
        errors++;
        $display("FAIL rand_ready[%0d] got %b want %b", i, in_ready_3, exp_rdy);
      end
      if (out_valid_3 === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rand_valid_empty[%0d] got v=1 d=%h want v=0", i, out_data_3);
        end else if (r) begin
          if (out_data_3 !== exp_q[0]) begin
            errors++;
            $display("FAIL rand_data[%0d] got %h want %h", i, out_data_3, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
      end
      if (fl) begin
        exp_q.delete();
      end else if (v && exp_rdy) begin
        exp_q.push_back(d);
      end
      step();
      checks++;
      if (int'(count_3) != exp_q.size() || int'(count_3) > 3) begin
        errors++;
        $display("FAIL rand_count[%0d] got %0d want %0d", i, count_3, exp_q.size());
      end
    end
    checks++;
    if (exp_q.size() != 0 || out_valid_3 !== 1'b0) begin
      errors++;
      $display("FAIL rand_drain got v=%b left=%0d want v=0 left=0", out_valid_3, exp_q.size());
    end
    drive_3(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_async_reset();
    drive_1(1'b0, 1'b1, 8'h3C, 1'b0);
    step();
    drive_1(1'b0, 1'b0, 8'h00, 1'b0);
    checks++;
    if ({out_valid_1, out_data_1} !== {1'b1, 8'h3C}) begin
      errors++;
      $display("FAIL async_pre got v=%b d=%h want v=1 d=3c", out_valid_1, out_data_1);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({out_valid_1, out_data_1, count_1} !== {1'b0, BUB1, 1'b0}) begin
      errors++;
      $display("FAIL async_reset got v=%b d=%h c=%0d want v=0 d=%h c=0", out_valid_1, out_data_1, count_1, BUB1);
    end
    #1;
    reset = 1'b0;
    step();
    checks++;
    if ({in_ready_1, out_valid_1} !== 2'b10) begin
      errors++;
      $display("FAIL async_release got rdy=%b v=%b want rdy=1 v=0", in_ready_1, out_valid_1);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_all();
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_full_simultaneous();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
